// File: rtl/dmem_arbiter_pkg.sv
// Shared widths and FSM state encodings for the data-RAM arbiter.
package dmem_arbiter_pkg;

  localparam int unsigned RAM_ADDR_WIDTH = 12;
  localparam int unsigned RAM_DATA_WIDTH = 32;
  localparam int unsigned BE_WIDTH       = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CPU_RD = 2'd1,
    S_AUX_RD = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Single-port BRAM arbiter: CPU-first sharing with an aux requester, plus the
// stall/write-back-inhibit sequencing that turns a CPU load into 2 cycles.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = RAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = RAM_DATA_WIDTH,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  gated_clk,
  input  logic                  rst,
  input  logic                  cpu_r_enb,
  input  logic                  cpu_w_enb,
  input  logic [ADDR_WIDTH-1:0] cpu_r_addr,
  input  logic [ADDR_WIDTH-1:0] cpu_w_addr,
  input  logic [DATA_WIDTH-1:0] cpu_w_dat,
  input  logic [BE_WIDTH-1:0]   cpu_w_byte_enb,
  output logic [DATA_WIDTH-1:0] cpu_r_dat,
  output logic                  cpu_stall,
  output logic                  cpu_wb_inhibit,
  input  logic                  aux_req,
  input  logic                  aux_we,
  input  logic [ADDR_WIDTH-1:0] aux_addr,
  input  logic [DATA_WIDTH-1:0] aux_wdat,
  input  logic [BE_WIDTH-1:0]   aux_be,
  output logic                  aux_gnt,
  output logic                  aux_rvalid,
  output logic [DATA_WIDTH-1:0] aux_rdat,
  output logic                  ram_en,
  output logic [BE_WIDTH-1:0]   ram_we,
  output logic [ADDR_WIDTH-3:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdat,
  input  logic [DATA_WIDTH-1:0] ram_rdat
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  arb_state_e       state;
  arb_state_e       state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic             starve_sat;
  logic             cpu_req;
  logic             aux_win;
  logic             cpu_win;

  // Byte offsets are irrelevant to a word-wide port.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_r_addr[1:0], cpu_w_addr[1:0], aux_addr[1:0]};

  assign cpu_req    = cpu_r_enb | cpu_w_enb;
  assign starve_sat = (starve_cnt >= CNT_W'(STARVE_LIMIT));
  assign aux_win    = (state == S_IDLE) && aux_req && (!cpu_req || starve_sat);
  assign cpu_win    = (state == S_IDLE) && !aux_win && cpu_req;

  // State register.
  always_ff @(posedge gated_clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a store (even alongside a load) never leaves S_IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (aux_win)                     state_nxt = aux_we ? S_IDLE : S_AUX_RD;
        else if (cpu_win && !cpu_w_enb)  state_nxt = S_CPU_RD;
        else                             state_nxt = S_IDLE;
      end
      S_CPU_RD: state_nxt = S_IDLE;
      S_AUX_RD: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Anti-starvation counter: counts consecutive denied aux cycles.
  always_ff @(posedge gated_clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (aux_req && !aux_win) begin
      if (!starve_sat) starve_cnt <= starve_cnt + CNT_W'(1);
    end else begin
      starve_cnt <= '0;
    end
  end

  // Output logic; everything is held at zero while reset is asserted.
  always_comb begin
    cpu_r_dat      = '0;
    cpu_stall      = 1'b0;
    cpu_wb_inhibit = 1'b0;
    aux_gnt        = 1'b0;
    aux_rvalid     = 1'b0;
    aux_rdat       = '0;
    ram_en         = 1'b0;
    ram_we         = '0;
    ram_addr       = '0;
    ram_wdat       = '0;
    if (!rst) begin
      cpu_r_dat = ram_rdat;
      aux_rdat  = ram_rdat;
      case (state)
        S_IDLE: begin
          if (aux_win) begin
            aux_gnt        = 1'b1;
            ram_en         = 1'b1;
            ram_we         = aux_we ? aux_be : '0;
            ram_addr       = aux_addr[ADDR_WIDTH-1:2];
            ram_wdat       = aux_wdat;
            cpu_stall      = cpu_req;
            cpu_wb_inhibit = cpu_req;
          end else if (cpu_win && cpu_w_enb) begin
            ram_en   = 1'b1;
            ram_we   = cpu_w_byte_enb;
            ram_addr = cpu_w_addr[ADDR_WIDTH-1:2];
            ram_wdat = cpu_w_dat;
          end else if (cpu_win) begin
            ram_en         = 1'b1;
            ram_addr       = cpu_r_addr[ADDR_WIDTH-1:2];
            ram_wdat       = cpu_w_dat;
            cpu_stall      = 1'b1;
            cpu_wb_inhibit = 1'b1;
          end
        end
        S_AUX_RD: begin
          aux_rvalid     = 1'b1;
          cpu_stall      = cpu_req;
          cpu_wb_inhibit = cpu_req;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 1-cycle-latency byte-writable BRAM model.
module tb_dmem_arbiter;

  logic        gated_clk;
  logic        rst;
  logic        cpu_r_enb, cpu_w_enb;
  logic [11:0] cpu_r_addr, cpu_w_addr;
  logic [31:0] cpu_w_dat;
  logic [3:0]  cpu_w_byte_enb;
  logic [31:0] cpu_r_dat;
  logic        cpu_stall, cpu_wb_inhibit;
  logic        aux_req, aux_we;
  logic [11:0] aux_addr;
  logic [31:0] aux_wdat;
  logic [3:0]  aux_be;
  logic        aux_gnt, aux_rvalid;
  logic [31:0] aux_rdat;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdat, ram_rdat;

  logic [31:0] mem [0:1023];
  int total = 0;
  int bad   = 0;

  dmem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .gated_clk(gated_clk), .rst(rst),
    .cpu_r_enb(cpu_r_enb), .cpu_w_enb(cpu_w_enb),
    .cpu_r_addr(cpu_r_addr), .cpu_w_addr(cpu_w_addr),
    .cpu_w_dat(cpu_w_dat), .cpu_w_byte_enb(cpu_w_byte_enb),
    .cpu_r_dat(cpu_r_dat), .cpu_stall(cpu_stall), .cpu_wb_inhibit(cpu_wb_inhibit),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr),
    .aux_wdat(aux_wdat), .aux_be(aux_be),
    .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdat(aux_rdat),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdat(ram_wdat), .ram_rdat(ram_rdat)
  );

  initial gated_clk = 1'b0;
  always #5 gated_clk = ~gated_clk;

  // Synchronous-read BRAM, read-before-write, per-byte write enables.
  always @(posedge gated_clk) begin
    if (ram_en) begin
      ram_rdat <= mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdat[8*b +: 8];
    end
  end

  // Simultaneous load and store requests are illegal.
  always @(negedge gated_clk) begin
    if (!rst)
      assert (!(cpu_r_enb && cpu_w_enb)) else begin
        bad++;
        $error("FAIL illegal_rw cpu_r_enb=%0b cpu_w_enb=%0b", cpu_r_enb, cpu_w_enb);
      end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge gated_clk);
    #1;
  endtask

  task automatic smp();
    @(negedge gated_clk);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[4]  = 32'hDEADBEEF;
    mem[8]  = 32'hAABBCCDD;
    mem[16] = 32'h16161616;
    rst = 1'b1;
    cpu_r_enb = 1'b1; cpu_w_enb = 1'b0;
    cpu_r_addr = 12'h010; cpu_w_addr = 12'h0; cpu_w_dat = 32'h0; cpu_w_byte_enb = 4'h0;
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 12'h040; aux_wdat = 32'h0; aux_be = 4'h0;

    // Reset holds every output low even with requests present.
    smp();
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_aux_gnt", 32'(aux_gnt), 32'd0);
    chk("rst_cpu_r_dat", cpu_r_dat, 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    tick();
    rst = 1'b0; cpu_r_enb = 1'b0; aux_req = 1'b0;
    tick();

    // Uncontended load of word 4.
    cpu_r_enb = 1'b1; cpu_r_addr = 12'h010;
    smp();
    chk("ld_ram_en", 32'(ram_en), 32'd1);
    chk("ld_ram_addr", 32'(ram_addr), 32'd4);
    chk("ld_ram_we", 32'(ram_we), 32'd0);
    chk("ld_stall", 32'(cpu_stall), 32'd1);
    chk("ld_inhibit", 32'(cpu_wb_inhibit), 32'd1);
    tick();
    smp();
    chk("ld_data", cpu_r_dat, 32'hDEADBEEF);
    chk("ld_d_stall", 32'(cpu_stall), 32'd0);
    chk("ld_d_inhibit", 32'(cpu_wb_inhibit), 32'd0);
    chk("ld_d_ram_en", 32'(ram_en), 32'd0);
    tick();
    cpu_r_enb = 1'b0;

    // Half-word store into word 8.
    cpu_w_enb = 1'b1; cpu_w_addr = 12'h020; cpu_w_byte_enb = 4'b0011; cpu_w_dat = 32'h00001234;
    smp();
    chk("st_ram_en", 32'(ram_en), 32'd1);
    chk("st_ram_we", 32'(ram_we), 32'h3);
    chk("st_ram_addr", 32'(ram_addr), 32'd8);
    chk("st_ram_wdat", ram_wdat, 32'h00001234);
    chk("st_stall", 32'(cpu_stall), 32'd0);
    tick();
    cpu_w_enb = 1'b0;

    // Read back the merged word; ram_wdat is zero while the port is idle.
    cpu_r_enb = 1'b1; cpu_r_addr = 12'h020;
    tick();
    smp();
    chk("rb_data", cpu_r_dat, 32'hAABB1234);
    chk("idle_wdat", ram_wdat, 32'h0);
    tick();
    cpu_r_enb = 1'b0;

    // CPU load and aux write together: CPU first, aux granted in cycle 2.
    cpu_r_enb = 1'b1; cpu_r_addr = 12'h010;
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 12'h030; aux_wdat = 32'hCAFEF00D; aux_be = 4'hF;
    smp();
    chk("cw_c0_gnt", 32'(aux_gnt), 32'd0);
    chk("cw_c0_addr", 32'(ram_addr), 32'd4);
    tick();
    smp();
    chk("cw_c1_gnt", 32'(aux_gnt), 32'd0);
    chk("cw_c1_data", cpu_r_dat, 32'hDEADBEEF);
    tick();
    cpu_r_enb = 1'b0;
    smp();
    chk("cw_c2_gnt", 32'(aux_gnt), 32'd1);
    chk("cw_c2_we", 32'(ram_we), 32'hF);
    chk("cw_c2_addr", 32'(ram_addr), 32'd12);
    chk("cw_c2_wdat", ram_wdat, 32'hCAFEF00D);
    tick();
    aux_req = 1'b0; aux_we = 1'b0;
    chk("cw_mem", mem[12], 32'hCAFEF00D);

    // Continuous CPU loads starve aux read of 0x040 until the counter hits 4.
    cpu_r_enb = 1'b1; cpu_r_addr = 12'h010;
    aux_req = 1'b1; aux_addr = 12'h040;
    for (int c = 0; c < 4; c++) begin
      smp();
      chk($sformatf("sv_c%0d_gnt", c), 32'(aux_gnt), 32'd0);
      chk($sformatf("sv_c%0d_en", c), 32'(ram_en), (c % 2 == 0) ? 32'd1 : 32'd0);
      tick();
    end
    smp();
    chk("sv_gnt", 32'(aux_gnt), 32'd1);
    chk("sv_gnt_addr", 32'(ram_addr), 32'd16);
    chk("sv_gnt_we", 32'(ram_we), 32'd0);
    chk("sv_gnt_stall", 32'(cpu_stall), 32'd1);
    chk("sv_gnt_inh", 32'(cpu_wb_inhibit), 32'd1);
    tick();
    aux_req = 1'b0;
    smp();
    chk("sv_rvalid", 32'(aux_rvalid), 32'd1);
    chk("sv_rdat", aux_rdat, 32'h16161616);
    chk("sv_rd_stall", 32'(cpu_stall), 32'd1);
    chk("sv_rd_gnt", 32'(aux_gnt), 32'd0);
    chk("sv_rd_en", 32'(ram_en), 32'd0);
    tick();
    smp();
    chk("sv_cpu_issue", 32'(ram_en), 32'd1);
    chk("sv_cpu_rvalid", 32'(aux_rvalid), 32'd0);
    tick();
    smp();
    chk("sv_cpu_data", cpu_r_dat, 32'hDEADBEEF);
    chk("sv_cpu_stall", 32'(cpu_stall), 32'd0);
    tick();
    cpu_r_enb = 1'b0;

    // Aux read on an idle port, CPU load arrives during S_AUX_RD.
    aux_req = 1'b1; aux_addr = 12'h040;
    smp();
    chk("ar_gnt", 32'(aux_gnt), 32'd1);
    chk("ar_stall0", 32'(cpu_stall), 32'd0);
    tick();
    aux_req = 1'b0;
    cpu_r_enb = 1'b1; cpu_r_addr = 12'h020;
    smp();
    chk("ar_rvalid", 32'(aux_rvalid), 32'd1);
    chk("ar_rdat", aux_rdat, 32'h16161616);
    chk("ar_stall", 32'(cpu_stall), 32'd1);
    chk("ar_inhibit", 32'(cpu_wb_inhibit), 32'd1);
    tick();
    smp();
    chk("ar_issue_en", 32'(ram_en), 32'd1);
    chk("ar_issue_addr", 32'(ram_addr), 32'd8);
    tick();
    smp();
    chk("ar_data", cpu_r_dat, 32'hAABB1234);
    chk("ar_d_stall", 32'(cpu_stall), 32'd0);
    tick();
    cpu_r_enb = 1'b0;

    // Reset pulsed during S_CPU_RD aborts; the held load then completes in 2 cycles.
    cpu_r_enb = 1'b1; cpu_r_addr = 12'h010;
    tick();
    rst = 1'b1;
    smp();
    chk("ra_cpu_r_dat", cpu_r_dat, 32'd0);
    chk("ra_ram_en", 32'(ram_en), 32'd0);
    chk("ra_stall", 32'(cpu_stall), 32'd0);
    chk("ra_rvalid", 32'(aux_rvalid), 32'd0);
    tick();
    rst = 1'b0;
    smp();
    chk("ra_re_en", 32'(ram_en), 32'd1);
    chk("ra_re_addr", 32'(ram_addr), 32'd4);
    chk("ra_re_stall", 32'(cpu_stall), 32'd1);
    tick();
    smp();
    chk("ra_re_data", cpu_r_dat, 32'hDEADBEEF);
    chk("ra_re_stall1", 32'(cpu_stall), 32'd0);
    tick();
    cpu_r_enb = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port data-RAM arbiter and load sequencer for the rv32i core. It sits between the core's data-RAM port, an auxiliary requester (fault-injection / DMA memory port) and one synchronous-read BRAM port with 1-cycle read latency. It converts the core's single-cycle load into a 2-cycle access by driving `pc_stall` and a write-back inhibit. It also shares the port with the auxiliary requester using CPU-first priority plus an anti-starvation counter.

## Interface
Parameters:
- `ADDR_WIDTH`, default `` `RAM_ADDR_WIDTH ``: byte-address width of both requesters.
- `DATA_WIDTH`, default `` `DATA_WIDTH ``: word width, 32.
- `STARVE_LIMIT`, default 4: number of consecutive denied aux cycles after which aux overrides the CPU.

Ports:
- `gated_clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `cpu_r_enb` / `cpu_w_enb`, in, 1 each: core load / store request, level-held while the PC is stalled.
- `cpu_r_addr` / `cpu_w_addr`, in, ADDR_WIDTH each: byte addresses.
- `cpu_w_dat`, in, DATA_WIDTH: store data. `cpu_w_byte_enb`, in, 4: store byte enables.
- `cpu_r_dat`, out, DATA_WIDTH: load data returned to the byte reader.
- `cpu_stall`, out, 1: drives the core's `pc_stall`.
- `cpu_wb_inhibit`, out, 1: the core ANDs its inverse into the regfile write enable.
- `aux_req`, `aux_we`, in, 1 each. `aux_addr`, in, ADDR_WIDTH. `aux_wdat`, in, DATA_WIDTH. `aux_be`, in, 4.
- `aux_gnt`, out, 1: aux access is issued this cycle.
- `aux_rvalid`, out, 1. `aux_rdat`, out, DATA_WIDTH.
- `ram_en`, out, 1. `ram_we`, out, 4. `ram_addr`, out, ADDR_WIDTH-2 (word index). `ram_wdat`, out, DATA_WIDTH. `ram_rdat`, in, DATA_WIDTH.

## Operation
- FSM states:
  - `S_IDLE`: the port is free for a new issue.
  - `S_CPU_RD`: CPU load data is on `ram_rdat`.
  - `S_AUX_RD`: aux load data is on `ram_rdat`.
- Winner in `S_IDLE`:
  - Aux wins if `aux_req` and (no CPU request, or `starve_cnt >= STARVE_LIMIT`).
  - Otherwise the CPU wins if it has a request.
- CPU store win: issue the write, with `ram_we = cpu_w_byte_enb`, `ram_addr = cpu_w_addr[ADDR_WIDTH-1:2]`. No stall. Stay in `S_IDLE`.
- CPU load win: issue the read with `ram_en=1`, `ram_we=0`. Assert `cpu_stall=1` and `cpu_wb_inhibit=1`. Go to `S_CPU_RD`.
- `S_CPU_RD`:
  - `cpu_r_dat = ram_rdat`, `cpu_stall=0`, `cpu_wb_inhibit=0`. The core commits at this edge.
  - The port is idle (`ram_en=0`). Go to `S_IDLE`.
- Aux win:
  - `aux_gnt=1` and the aux access is issued.
  - Aux write stays in `S_IDLE`. Aux read goes to `S_AUX_RD`.
  - A losing CPU request sees `cpu_stall=1` and `cpu_wb_inhibit=1`.
- `S_AUX_RD`:
  - `aux_rvalid=1`, `aux_rdat = ram_rdat`. The port is idle.
  - `cpu_stall` and `cpu_wb_inhibit` are asserted if the CPU has a pending request. Go to `S_IDLE`.
- `starve_cnt`:
  - Increments (saturating at STARVE_LIMIT) on every cycle with `aux_req && !aux_gnt`.
  - Clears on `aux_gnt` or when `aux_req` is low.
- Aux rules:
  - `aux_req` must be held until `aux_gnt`.
  - Aux address and data are sampled only in the grant cycle.
  - `aux_gnt` is never asserted outside `S_IDLE`.
- `cpu_r_enb && cpu_w_enb` together is illegal. The store takes precedence and the bench flags an assertion.
- `cpu_r_dat` and `aux_rdat` are don't-care (driven from `ram_rdat`) outside their valid states.
- `ram_wdat` is muxed from the winner and is 0 when the port is idle.

## Timing
- While `rst` is high: state `S_IDLE`, `starve_cnt=0`, and every output is forced to 0.
- Reset mid-access (any state) aborts the access. The core reissues its request after reset.
- Outputs are combinational from the state and current inputs. The state and counter are the only flops.
- CPU load, uncontended: 2 cycles (issue + data). CPU store: 1 cycle.
- Aux write: 1 cycle after grant. Aux read: `aux_rvalid` arrives exactly 1 cycle after `aux_gnt`.
- Worst-case CPU penalty per aux read: 2 extra cycles.
- Worst-case aux wait under continuous CPU traffic: STARVE_LIMIT + 2 cycles.
- Back-to-back CPU loads alternate `S_IDLE` and `S_CPU_RD`, sustaining 1 load per 2 cycles.

## Structure
- A new `rv32i_dmem_arb.vh` include holds the state encodings (`S_IDLE=2'd0`, `S_CPU_RD=2'd1`, `S_AUX_RD=2'd2`). `RAM_ADDR_WIDTH` and `DATA_WIDTH` keep coming from `rv32i_params.vh`.
- Single flat module. The starvation counter is too small to justify a sub-module.
- `riscv_cpu` changes:
  - `pc_stall` is driven from `cpu_stall`.
  - The regfile write enable is gated by `!cpu_wb_inhibit`.
  - Both changes apply only while `cm_cpu_stop` is low.

## Test plan
- Uncontended load, `cpu_r_addr=0x010`, RAM word 4 = 0xDEADBEEF → cycle 0: `ram_en=1`, `ram_addr=4`, `cpu_stall=1`, `cpu_wb_inhibit=1`. Cycle 1: `cpu_r_dat=0xDEADBEEF`, `cpu_stall=0`.
- Store to 0x020, be=4'b0011, data=0x00001234 → same cycle: `ram_we=0011`, `ram_addr=8`, `ram_wdat=0x1234`, `cpu_stall=0`.
- CPU load and aux write both raised in `S_IDLE`, counter 0 → CPU issues first. `aux_gnt=1` in cycle 2, provided the CPU is idle then.
- Continuous CPU loads with aux read of 0x040 held → `starve_cnt` reaches 4, then `aux_gnt`. CPU is stalled for the grant and `S_AUX_RD` cycles. `aux_rvalid=1` next cycle with RAM word 16.
- Aux read granted while the CPU is idle, CPU load arrives in the `S_AUX_RD` cycle → CPU is stalled that cycle, issued the next cycle, data the cycle after.
- `rst` pulsed during `S_CPU_RD` → all outputs 0, state `S_IDLE`, counter 0. After release, the reissued load completes in 2 cycles.
